load_store_unit: RTL and testbench

//  Memory-access stage between execute and the register file. Takes one decoded

---
 rtl/cpu_pkg.sv | 11 +
 rtl/lsu_align.sv | 25 ++
 rtl/load_store_unit.sv | 97 +++++++++
 tb/tb_load_store_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, funct3 codes and LSU state encoding
package cpu_pkg;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB, S_ERR} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering/strobes and load byte/half extraction with extension
module lsu_align import cpu_pkg::*; (
    input  logic [2:0]  st_f3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ldata
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b     = rdata[{ld_off, 3'b000} +: 8];
        h     = rdata[{ld_off[1], 4'b0000} +: 16];
        wdata = st_f3 == F3_B ? {4{st_data[7:0]}} : st_f3 == F3_H ? {2{st_data[15:0]}} : st_data;
        wstrb = st_f3 == F3_B ? 4'b0001 << st_off : st_f3 == F3_H ? 4'b0011 << st_off : 4'b1111;
        ldata = ld_f3 == F3_B  ? {{24{b[7]}}, b} :
                ld_f3 == F3_BU ? {24'b0, b} :
                ld_f3 == F3_H  ? {{16{h[15]}}, h} :
                ld_f3 == F3_HU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage running one load/store per req/ack transaction
module load_store_unit import cpu_pkg::*; #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_en_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o
);
    lsu_state_t  state;
    logic [31:0] imm, addr, cnt, wdata_c, ldata;
    logic [3:0]  wstrb_c;
    logic [2:0]  f3, f3_r;
    logic [1:0]  off_r;
    logic        is_ld, is_st, accept, misal, timeout, st_done, unused_rs;
    assign f3        = instr_i[14:12];
    assign is_ld     = instr_i[6:0] == OPC_LOAD && (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    assign is_st     = instr_i[6:0] == OPC_STORE && (f3 == F3_B || f3 == F3_H || f3 == F3_W);
    assign accept    = state == S_IDLE && valid_i && (is_ld || is_st);
    assign imm       = is_st ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} : {{20{instr_i[31]}}, instr_i[31:20]};
    assign addr      = rs1_data_i + imm;
    // funct3[1:0] encodes width for both signed and unsigned variants
    assign misal     = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign timeout   = TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1);
    assign unused_rs = ^instr_i[19:15];
    assign busy_o    = state != S_IDLE;
    assign done_o    = state == S_WB || st_done;
    assign err_o     = state == S_ERR;
    assign mem_req_o = state == S_ACCESS;
    assign wb_en_o   = state == S_WB && wb_rd_o != 5'd0;
    lsu_align u_align (
        .st_f3  (f3),
        .st_off (addr[1:0]),
        .st_data(rs2_data_i),
        .wstrb  (wstrb_c),
        .wdata  (wdata_c),
        .ld_f3  (f3_r),
        .ld_off (off_r),
        .rdata  (mem_rdata_i),
        .ldata  (ldata)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            st_done     <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wstrb_o <= '0;
            mem_wdata_o <= '0;
            wb_rd_o     <= '0;
            wb_data_o   <= '0;
            f3_r        <= '0;
            off_r       <= '0;
        end else begin
            st_done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    state       <= misal ? S_ERR : S_ACCESS;
                    cnt         <= '0;
                    mem_we_o    <= is_st;
                    mem_addr_o  <= {addr[31:2], 2'b00};
                    mem_wstrb_o <= is_st ? wstrb_c : 4'b0000;
                    mem_wdata_o <= is_st ? wdata_c : 32'h0;
                    wb_rd_o     <= instr_i[11:7];
                    f3_r        <= f3;
                    off_r       <= addr[1:0];
                end
                S_ACCESS: if (mem_ack_i) begin
                    state     <= mem_we_o ? S_IDLE : S_WB;
                    st_done   <= mem_we_o;
                    wb_data_o <= ldata;
                end else if (timeout) begin
                    state <= S_ERR;
                end else begin
                    cnt <= cnt + 32'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a simple acking memory model
module tb_load_store_unit;
    import cpu_pkg::*;
    typedef struct packed {
        logic        is_err;
        logic        is_st;
        logic        req;
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } exp_t;
    logic        clk = 0, rst = 1, valid_i = 0, mem_ack_i = 0;
    logic [31:0] instr_i = 0, rs1_data_i = 0, rs2_data_i = 0, mem_rdata_i = 0;
    logic        busy_o, done_o, err_o, mem_req_o, mem_we_o, wb_en_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
    logic [3:0]  mem_wstrb_o;
    logic [4:0]  wb_rd_o;
    exp_t        sb[$];
    exp_t        e_m;
    int          n_chk = 0, n_pass = 0, req_cnt = 0, ack_dly = 0;
    bit          ack_en = 0, force_ack = 0, req_seen = 0, ok;
    logic [31:0] rdata_v = 0;
    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .instr_i(instr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .wb_en_o(wb_en_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", tag, act, exp);
        else n_pass++;
    endtask
    function automatic logic [31:0] i_ld(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, OPC_LOAD};
    endfunction
    function automatic logic [31:0] i_st(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], OPC_STORE};
    endfunction
    function automatic exp_t mk(input bit er, input bit st, input bit rq, input bit wb, input logic [4:0] rd,
                                input logic [31:0] data, input logic [31:0] addr, input logic [3:0] strb,
                                input logic [31:0] wdata);
        return '{er, st, rq, wb, rd, data, addr, strb, wdata};
    endfunction
    // memory responder and scoreboard monitor, both on the falling edge
    always @(negedge clk) begin
        if (mem_req_o) begin
            mem_ack_i = ack_en && req_cnt >= ack_dly;
            req_cnt++;
        end else begin
            mem_ack_i = force_ack;
            req_cnt = 0;
        end
        mem_rdata_i = rdata_v;
        if (rst) req_seen = 0;
        else begin
            if (mem_req_o && !req_seen) begin
                req_seen = 1;
                ok = sb.size() != 0;
                if (ok) ok = sb[0].req;
                chk("req_expected", 32'(ok), 1);
                if (ok) begin
                    chk("mem_addr", mem_addr_o, sb[0].addr);
                    chk("mem_we", 32'(mem_we_o), 32'(sb[0].is_st));
                    chk("mem_wstrb", 32'(mem_wstrb_o), 32'(sb[0].strb));
                    if (sb[0].is_st) chk("mem_wdata", mem_wdata_o, sb[0].wdata);
                end
            end
            if (done_o || err_o) begin
                chk("retire_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e_m = sb.pop_front();
                    chk("err", 32'(err_o), 32'(e_m.is_err));
                    chk("done", 32'(done_o), 32'(!e_m.is_err));
                    chk("wb_en", 32'(wb_en_o), 32'(e_m.wb));
                    chk("req_made", 32'(req_seen), 32'(e_m.req));
                    if (e_m.wb) begin
                        chk("wb_rd", 32'(wb_rd_o), 32'(e_m.rd));
                        chk("wb_data", wb_data_o, e_m.data);
                    end
                end
                req_seen = 0;
            end else chk("wb_en_idle", 32'(wb_en_o), 0);
        end
    end
    task automatic run(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] rd_v, input int dly, input bit aen, input exp_t e,
                       input int lat, input bit poke);
        int n;
        @(negedge clk);
        ack_dly = dly; ack_en = aen; rdata_v = rd_v;
        sb.push_back(e);
        instr_i = ins; rs1_data_i = r1; rs2_data_i = r2; valid_i = 1;
        @(negedge clk);
        valid_i = 0;
        n = 0;
        while (!(done_o || err_o) && n < 20) begin
            if (poke && n == 1) begin
                chk("busy_poke", 32'(busy_o), 1);
                valid_i = 1; instr_i = i_st(12'h0, F3_W);
            end else valid_i = 0;
            @(negedge clk);
            n++;
        end
        valid_i = 0;
        chk("latency", n, lat);
        @(negedge clk);
        chk("busy_after", 32'(busy_o), 0);
        chk("sb_empty", sb.size(), 0);
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_req", 32'(mem_req_o), 0);
        chk("rst_flags", {done_o, err_o, wb_en_o, mem_we_o}, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wb", {wb_rd_o, wb_data_o[26:0]}, 0);
        rst = 0;
        run(i_ld(12'd4, F3_W, 5'd5), 32'h100, 0, 32'hDEADBEEF, 1, 1,
            mk(0, 0, 1, 1, 5'd5, 32'hDEADBEEF, 32'h104, 4'b0, 0), 2, 0);
        run(i_ld(12'd3, F3_B, 5'd6), 32'h100, 0, 32'h80FF_0000, 0, 1,
            mk(0, 0, 1, 1, 5'd6, 32'hFFFFFF80, 32'h100, 4'b0, 0), 1, 0);
        run(i_ld(12'd3, F3_BU, 5'd7), 32'h100, 0, 32'h80FF_0000, 0, 1,
            mk(0, 0, 1, 1, 5'd7, 32'h00000080, 32'h100, 4'b0, 0), 1, 0);
        run(i_ld(12'd2, F3_H, 5'd8), 32'h100, 0, 32'h8001_1234, 0, 1,
            mk(0, 0, 1, 1, 5'd8, 32'hFFFF8001, 32'h100, 4'b0, 0), 1, 0);
        run(i_ld(12'd0, F3_HU, 5'd9), 32'h100, 0, 32'h1234_F00F, 2, 1,
            mk(0, 0, 1, 1, 5'd9, 32'h0000F00F, 32'h100, 4'b0, 0), 3, 0);
        run(i_st(12'hFFE, F3_H), 32'h10, 32'h1234ABCD, 0, 0, 1,
            mk(0, 1, 1, 0, 0, 0, 32'h0C, 4'b1100, 32'hABCDABCD), 1, 0);
        run(i_st(12'd1, F3_B), 32'h40, 32'h000000AB, 0, 0, 1,
            mk(0, 1, 1, 0, 0, 0, 32'h40, 4'b0010, 32'hABABABAB), 1, 0);
        run(i_st(12'd0, F3_W), 32'h50, 32'hCAFEF00D, 0, 1, 1,
            mk(0, 1, 1, 0, 0, 0, 32'h50, 4'b1111, 32'hCAFEF00D), 2, 0);
        run(i_ld(12'd8, F3_W, 5'd10), 32'hFFFFFFFC, 0, 32'h0BADF00D, 0, 1,
            mk(0, 0, 1, 1, 5'd10, 32'h0BADF00D, 32'h4, 4'b0, 0), 1, 0);
        run(i_ld(12'd2, F3_W, 5'd11), 32'h100, 0, 0, 0, 1,
            mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        run(i_st(12'd1, F3_H), 32'h100, 32'h55, 0, 0, 1,
            mk(1, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0);
        run(i_ld(12'd0, F3_W, 5'd3), 32'h200, 0, 0, 0, 0,
            mk(1, 0, 1, 0, 0, 0, 32'h200, 4'b0, 0), 4, 1);
        @(negedge clk);
        instr_i = 32'h00100093; valid_i = 1;
        @(negedge clk);
        chk("ignore_alu", 32'(busy_o), 0);
        instr_i = i_ld(12'd0, 3'b011, 5'd4);
        @(negedge clk);
        valid_i = 0;
        chk("ignore_f3", 32'(busy_o), 0);
        ack_en = 0;
        sb.push_back(mk(0, 0, 1, 1, 5'd9, 0, 32'h400, 4'b0, 0));
        instr_i = i_ld(12'd0, F3_W, 5'd9); rs1_data_i = 32'h400; valid_i = 1;
        @(negedge clk);
        valid_i = 0;
        @(negedge clk);
        chk("pre_rst_req", 32'(mem_req_o), 1);
        rst = 1;
        sb.delete();
        @(negedge clk);
        rst = 0;
        chk("rst_mid_req", 32'(mem_req_o), 0);
        chk("rst_mid_busy", 32'(busy_o), 0);
        force_ack = 1; rdata_v = 32'h12345678;
        @(negedge clk);
        force_ack = 0;
        repeat (3) begin
            chk("late_ack_done", 32'(done_o), 0);
            chk("late_ack_wb", 32'(wb_en_o), 0);
            @(negedge clk);
        end
        run(i_ld(12'd0, F3_W, 5'd0), 32'h300, 0, 32'h55, 0, 1,
            mk(0, 0, 1, 0, 5'd0, 0, 32'h300, 4'b0, 0), 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
